// File: rtl/window_packer.sv
// Packs a row-major byte stream into a flat WS_I x WS_J window, byte 0 in the MSBs.
// Emits a one-cycle output_valid per window and realigns on pixel_first mid-fill.
module window_packer #(
  parameter int WS_I  = 8,
  parameter int WS_J  = 8,
  parameter int BYTE  = 8,
  localparam int N_PIX  = WS_I * WS_J,
  localparam int N_BITS = N_PIX * BYTE,
  localparam int CW     = $clog2(N_PIX) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE-1:0]   pixel_in,
  input  logic              pixel_valid,
  input  logic              pixel_first,
  output logic [N_BITS-1:0] values,
  output logic              output_valid,
  output logic              sync_err,
  output logic [CW-1:0]     fill_count
);

  typedef enum logic {FILL, EMIT} state_t;

  localparam logic [CW-1:0] LAST = CW'(N_PIX - 1);

  state_t            state;
  logic [N_BITS-1:0] fill_reg;
  logic [N_BITS-1:0] shifted;

  always_comb begin
    shifted = (fill_reg << BYTE) | N_BITS'(pixel_in);
  end

  assign output_valid = (state == EMIT);

  // Realignment is checked before completion, so a flagged byte can never close a window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      fill_reg   <= '0;
      values     <= '0;
      fill_count <= '0;
      sync_err   <= 1'b0;
    end else begin
      state    <= FILL;
      sync_err <= 1'b0;
      if (pixel_valid) begin
        if (pixel_first && fill_count != '0) begin
          fill_reg   <= N_BITS'(pixel_in);
          fill_count <= CW'(1);
          sync_err   <= 1'b1;
        end else if (fill_count == LAST) begin
          fill_reg   <= shifted;
          values     <= shifted;
          fill_count <= '0;
          state      <= EMIT;
        end else begin
          fill_reg   <= shifted;
          fill_count <= fill_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_window_packer.sv
// Directed checks for window_packer: packing order, latency, realignment, reset and gapped input.
module tb_window_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   pixel_in;
  logic         pixel_valid;
  logic         pixel_first;
  logic [511:0] values;
  logic         output_valid;
  logic         sync_err;
  logic [6:0]   fill_count;

  int n_cmp = 0;
  int n_bad = 0;

  window_packer #(.WS_I(8), .WS_J(8), .BYTE(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .pixel_first  (pixel_first),
    .values       (values),
    .output_valid (output_valid),
    .sync_err     (sync_err),
    .fill_count   (fill_count)
  );

  always #5 clk = ~clk;

  // Observer: records every emitted window, sync_err pulses and illegal changes of values.
  logic [511:0] win_q[$];
  int           win_cyc[$];
  int           cyc = 0;
  int           err_pulses = 0;
  int           stab_err = 0;
  logic [511:0] last_values = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      if (output_valid) begin
        win_q.push_back(values);
        win_cyc.push_back(cyc);
      end else if (values !== last_values) begin
        stab_err <= stab_err + 1;
      end
      if (sync_err) err_pulses <= err_pulses + 1;
    end
    last_values <= values;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic f);
    @(negedge clk);
    pixel_valid = 1'b1;
    pixel_in    = b;
    pixel_first = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pixel_valid = 1'b0;
      pixel_first = 1'b0;
    end
  endtask

  logic [7:0] exp_b[64];

  function automatic logic [511:0] pack_exp();
    logic [511:0] v;
    v = '0;
    for (int k = 0; k < 64; k++) v[511-8*k -: 8] = exp_b[k];
    return v;
  endfunction

  int           n0, e0, sum;
  logic [511:0] w;
  logic [7:0]   rb;
  logic [7:0]   rnd_q[$];

  initial begin
    rst = 1'b0; pixel_in = '0; pixel_valid = 1'b0; pixel_first = 1'b0;
    idle(3);
    check("rst_values", values, '0);
    check("rst_ov", 512'(output_valid), 512'(0));
    check("rst_serr", 512'(sync_err), 512'(0));
    check("rst_fc", 512'(fill_count), 512'(0));
    rst = 1'b1;
    idle(2);

    // Constant window of 124
    for (int i = 0; i < 64; i++) send(8'd124, i == 0);
    idle(1);
    check("const_ov", 512'(output_valid), 512'(1));
    check("const_values", values, {64{8'd124}});
    sum = 0;
    for (int k = 0; k < 64; k++) begin
      w = values >> (8 * k);
      sum += int'(w[7:0]);
    end
    check("const_mean", 512'(sum / 64), 512'(124));
    idle(1);
    check("const_ov_1cyc", 512'(output_valid), 512'(0));
    check("const_hold", values, {64{8'd124}});

    // Ramp 0x00..0x3F
    for (int i = 0; i < 64; i++) begin send(8'(i), i == 0); exp_b[i] = 8'(i); end
    idle(1);
    check("ramp_ov", 512'(output_valid), 512'(1));
    check("ramp_msb", 512'(values[511:504]), 512'(8'h00));
    check("ramp_lsb", 512'(values[7:0]), 512'(8'h3F));
    check("ramp_full", values, pack_exp());
    check("ramp_fc", 512'(fill_count), 512'(0));
    idle(2);

    // 128 bytes back-to-back
    n0 = win_q.size();
    for (int i = 0; i < 128; i++) send(8'(i), i == 0);
    idle(3);
    check("b2b_count", 512'(win_q.size() - n0), 512'(2));
    if (win_q.size() >= n0 + 2) begin
      check("b2b_gap", 512'(win_cyc[n0+1] - win_cyc[n0]), 512'(64));
      for (int k = 0; k < 64; k++) exp_b[k] = 8'(k);
      check("b2b_win0", win_q[n0], pack_exp());
      for (int k = 0; k < 64; k++) exp_b[k] = 8'(64 + k);
      check("b2b_win1", win_q[n0+1], pack_exp());
    end

    // Realignment mid-fill
    n0 = win_q.size(); e0 = err_pulses;
    for (int i = 0; i < 20; i++) send(8'(8'h10 + i), i == 0);
    send(8'hAA, 1'b1);
    @(negedge clk);
    pixel_valid = 1'b0; pixel_first = 1'b1;
    check("sync_pulse", 512'(sync_err), 512'(1));
    check("sync_fc", 512'(fill_count), 512'(1));
    @(negedge clk);
    pixel_first = 1'b0;
    check("first_novalid_fc", 512'(fill_count), 512'(1));
    check("first_novalid_serr", 512'(sync_err), 512'(0));
    exp_b[0] = 8'hAA;
    for (int i = 0; i < 63; i++) begin send(8'(8'h40 + i), 1'b0); exp_b[i+1] = 8'(8'h40 + i); end
    idle(3);
    check("sync_err_count", 512'(err_pulses - e0), 512'(1));
    check("sync_win_count", 512'(win_q.size() - n0), 512'(1));
    if (win_q.size() > n0) begin
      check("sync_win", win_q[n0], pack_exp());
      w = win_q[n0];
      check("sync_byte0", 512'(w[511:504]), 512'(8'hAA));
    end

    // Reset mid-fill
    n0 = win_q.size();
    for (int i = 0; i < 30; i++) send(8'(8'hC0 + i), i == 0);
    @(negedge clk);
    pixel_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_values", values, '0);
    check("mid_rst_fc", 512'(fill_count), 512'(0));
    check("mid_rst_ov", 512'(output_valid | sync_err), 512'(0));
    idle(2);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin send(8'(8'h80 + i), 1'b0); exp_b[i] = 8'(8'h80 + i); end
    idle(3);
    check("post_rst_count", 512'(win_q.size() - n0), 512'(1));
    if (win_q.size() > n0) check("post_rst_win", win_q[n0], pack_exp());

    // Random gaps over three windows
    n0 = win_q.size();
    for (int i = 0; i < 192; i++) begin
      while ($urandom_range(1, 0) == 0) idle(1);
      rb = 8'($urandom);
      rnd_q.push_back(rb);
      send(rb, 1'b0);
    end
    idle(3);
    check("rand_count", 512'(win_q.size() - n0), 512'(3));
    for (int wdx = 0; wdx < 3; wdx++) begin
      for (int k = 0; k < 64; k++) exp_b[k] = rnd_q[64*wdx + k];
      if (win_q.size() > n0 + wdx) check($sformatf("rand_win%0d", wdx), win_q[n0+wdx], pack_exp());
    end
    check("values_stable", 512'(stab_err), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/window_packer.md
WINDOW_PACKER -- requirements
Module: window_packer

Interface
REQ-001 Parameter WS_I, default 8, window rows.
REQ-002 Parameter WS_J, default 8, window columns.
REQ-003 Parameter BYTE, default 8, bits per pixel; N_BITS = WS_I*WS_J*BYTE, N_PIX = WS_I*WS_J.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 pixel_in  input  BYTE  pixel byte, sampled only when pixel_valid=1.
REQ-007 pixel_valid  input  1  pixel_in valid this cycle; no backpressure, every valid byte SHALL be accepted.
REQ-008 pixel_first  input  1  qualified by pixel_valid; marks byte 0 of a new window.
REQ-009 values  output  N_BITS  packed window, the flat format consumed by the mean and var blocks.
REQ-010 output_valid  output  1  one-cycle pulse: values holds a new complete window.
REQ-011 sync_err  output  1  one-cycle pulse: window realigned mid-fill, partial data discarded.
REQ-012 fill_count  output  clog2(N_PIX)+1  bytes accepted into the window currently filling.

Function
REQ-013 The block SHALL accept pixels in row-major order, one byte per accepted cycle.
REQ-014 Byte k of a window (k = 0..N_PIX-1) SHALL appear at values[N_BITS-1-8k -: 8]; byte 0 is in the MSBs and byte N_PIX-1 is in the LSBs.
REQ-015 Internal fill register: each accepted byte SHALL shift in at the LSB, with the register shifting left by BYTE.
REQ-016 States: FILL (fill_count 0..N_PIX-1) and EMIT (one cycle, output_valid=1); there is no idle state, and FILL at count 0 is the resting condition.
REQ-017 FILL->EMIT: on the edge accepting byte N_PIX-1, the fill register contents plus that byte SHALL be copied to values, and fill_count SHALL return to 0.
REQ-018 Latency: output_valid SHALL be 1 in the cycle immediately after the edge that accepted the last byte, and SHALL be 1 for exactly one cycle.
REQ-019 values SHALL hold steady between windows and change only on the FILL->EMIT edge.
REQ-020 A byte accepted during the EMIT cycle SHALL become byte 0 of the next window, so back-to-back windows need zero gap cycles.
REQ-021 pixel_first=1 with fill_count=0 SHALL be a normal start, with no error.
REQ-022 pixel_first=1 with fill_count>0 SHALL discard the partial window, take this byte as byte 0 (fill_count becomes 1), and pulse sync_err in the next cycle; values is unchanged.
REQ-023 A byte with pixel_first=1 that completes a window is impossible by construction, because REQ-022 takes priority.
REQ-024 pixel_first while pixel_valid=0 SHALL be ignored.
REQ-025 Idle cycles (pixel_valid=0) SHALL hold fill_count and fill register unchanged, with no timeout.
REQ-026 fill_count SHALL wrap N_PIX-1 -> 0 only via REQ-017, and SHALL never reach N_PIX.

Reset
REQ-027 While rst=0: values=0, output_valid=0, sync_err=0, fill_count=0, and the fill register is cleared, all asynchronously.
REQ-028 Reset asserted mid-fill SHALL discard the partial window; no output_valid SHALL be generated for it.
REQ-029 After rst returns to 1, the first accepted byte SHALL be byte 0 whether or not pixel_first is set.

Verification
REQ-030 64 consecutive bytes of value 124, byte 0 flagged first -> output_valid one cycle after byte 63; values = 64 x 8'd124. Feeding values into mean SHALL give 124.
REQ-031 Bytes 0x00..0x3F in order -> values[511:504]=8'h00, values[7:0]=8'h3F, fill_count=0 during the output_valid cycle.
REQ-032 128 bytes with no gaps -> exactly two output_valid pulses, 64 cycles apart; the second window equals bytes 64..127.
REQ-033 20 bytes, then pixel_first with 0xAA, then 63 more bytes -> sync_err pulses once, exactly one window is emitted, and its byte 0 = 0xAA.
REQ-034 30 bytes, rst=0 for 2 cycles, then 64 bytes without pixel_first -> all outputs 0 during reset, then one window of exactly the post-reset bytes.
REQ-035 Random pixel_valid gaps (50% duty) over 3 windows -> contents match a scoreboard, and values is stable between pulses.
